stage_instruction_decode: RTL and testbench
===========================================

# stage_instruction_decode

Second pipeline stage of the RV32I core, directly downstream of instruction fetch. Consumes the fetched instruction word and its PC, drives the register-file read addresses, waits out the register-file read latency, and presents fully decoded fields (opcode, rd, funct3/funct7, sign-extended immediate, operand values) to execute. Uses the same enable/is_complete handshake as the other stages. Halts permanently on an undecodable opcode.

## Interface
- XLEN, 32, data/address width
- ILEN, 32, instruction width
- REG_READ_LATENCY, 1, register-file read latency in cycles; legal range 0..3
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- enable  in  1  held high by the controller until is_complete; low = stage idle
- instr_bits  in  ILEN  instruction from fetch; stable while enable is high
- pc  in  XLEN  PC of instr_bits; passed through
- rf_rs1_data, rf_rs2_data  in  XLEN  register-file read data
- rf_rs1_addr, rf_rs2_addr  out  5  register-file read addresses; combinational from instr_bits[19:15] / [24:20]
- is_complete  out  1  decode valid this cycle
- is_halted  out  1  sticky illegal-opcode flag
- opcode  out  opcode_t  decoded opcode
- rd  out  5;  funct3  out  3;  funct7  out  7
- imm  out  XLEN  sign-extended immediate
- rs1_value, rs2_value  out  XLEN  operand values
- pc_out  out  XLEN  PC associated with the outputs

## Operation
- Counter remaining_cycles, width $clog2(REG_READ_LATENCY+1), min 1: loads REG_READ_LATENCY while enable is low; decrements each cycle enable is high and it is nonzero.
- read_complete = (remaining_cycles == 0).
- next_halted = is_halted | (enable & read_complete & opcode == OPCODE_UNKNOWN). is_halted is registered from next_halted and cleared only by reset.
- is_complete = enable & read_complete & ~is_halted & ~next_halted.
- While enable & ~is_halted: all decoded outputs come combinationally from instr_bits, pc and rf data. Otherwise they come from the saved register set.
- Saved set captures the live outputs on every is_complete cycle and holds otherwise.
- Immediate by format:
  - I (OP_IMM, LOAD, JALR, SYSTEM): sext(instr[31:20])
  - S (STORE): sext({instr[31:25], instr[11:7]})
  - B (BRANCH): sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})
  - U (LUI, AUIPC): {instr[31:12], 12'b0}
  - J (JAL): sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0})
  - R (OP): 0
- Operand rule: source address 0 forces that value to 0, regardless of rf data.
- funct7 is passed raw; execute interprets it.

## Timing
- Reset (reset = 0, asynchronous): is_halted = 0; remaining_cycles = REG_READ_LATENCY; saved set = 0, so opcode, imm, pc_out, etc. all read 0; is_complete = 0.
- Latency: is_complete is first high REG_READ_LATENCY cycles after enable rises, counting the rising cycle as cycle 0. With latency 0 it is high in cycle 0.
- is_complete stays high while enable stays high after completion. The controller drops enable or advances the instruction; no re-read occurs.
- Enable dropped mid-read: counter reloads and outputs revert to the saved set. The next enable restarts the full latency.
- Illegal opcode: detected only at read_complete; is_complete never asserts; is_halted is high from the next cycle; later enables are ignored.
- Reset asserted mid-read: immediate return to reset state; no partial capture.

## Structure
- opcode_t, OPCODE_* values, extract_opcode and the immediate-format enum belong in the shared ISA types/constants package, reused by fetch and execute.
- XLEN, ILEN and register-index width come from the shared arch constants.
- One sub-module, immediate_generator: combinational instr_bits → imm.

## Test plan
- Decode ADDI x1,x2,-5 (0xFFB10093), latency 1, rf_rs1_data = 0x00000010:
  - rf_rs1_addr = 2 in cycle 0
  - is_complete in cycle 1 with rd = 1, imm = 0xFFFFFFFB, rs1_value = 0x10
- BEQ x0,x0,-4 (0xFE000EE3), rf data = 0xDEADBEEF: imm = 0xFFFFFFFC, rs1_value = rs2_value = 0.
- Immediate formats:
  - LUI x5,0x12345 (0x123452B7): imm = 0x12345000
  - JAL x1,+8 (0x008000EF): imm = 0x00000008
  - SW x2,12(x3) (0x0021A623): imm = 0x0000000C
- Latency 2, enable dropped in cycle 1 then reraised: is_complete two cycles after the re-rise; outputs between show the previously saved decode.
- instr_bits = 0x00000000 with enable high: is_complete never asserts, is_halted = 1 after read_complete; a following valid instruction is ignored until reset.
- Reset (reset = 0) in cycle 1 of a latency-2 read: outputs are 0 and is_halted = 0 immediately; after release a fresh read takes the full latency.

Source files
------------

// File: rtl/stage_instruction_decode_pkg.sv
// Shared ISA types and architecture constants for the RV32I pipeline:
// opcode encodings, immediate formats and the opcode/format helpers.
package stage_instruction_decode_pkg;

    localparam int ARCH_XLEN = 32;
    localparam int ARCH_ILEN = 32;
    localparam int REG_IDX_W = 5;

    typedef enum logic [6:0] {
        OPCODE_UNKNOWN = 7'b0000000,
        OPCODE_LUI     = 7'b0110111,
        OPCODE_AUIPC   = 7'b0010111,
        OPCODE_JAL     = 7'b1101111,
        OPCODE_JALR    = 7'b1100111,
        OPCODE_BRANCH  = 7'b1100011,
        OPCODE_LOAD    = 7'b0000011,
        OPCODE_STORE   = 7'b0100011,
        OPCODE_OP_IMM  = 7'b0010011,
        OPCODE_OP      = 7'b0110011,
        OPCODE_SYSTEM  = 7'b1110011
    } opcode_t;

    typedef enum logic [2:0] {
        IMM_R,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_t;

    // Any encoding outside the supported set collapses to OPCODE_UNKNOWN.
    function automatic opcode_t extract_opcode(input logic [ARCH_ILEN-1:0] instr);
        opcode_t op;
        case (instr[6:0])
            7'b0110111: op = OPCODE_LUI;
            7'b0010111: op = OPCODE_AUIPC;
            7'b1101111: op = OPCODE_JAL;
            7'b1100111: op = OPCODE_JALR;
            7'b1100011: op = OPCODE_BRANCH;
            7'b0000011: op = OPCODE_LOAD;
            7'b0100011: op = OPCODE_STORE;
            7'b0010011: op = OPCODE_OP_IMM;
            7'b0110011: op = OPCODE_OP;
            7'b1110011: op = OPCODE_SYSTEM;
            default:    op = OPCODE_UNKNOWN;
        endcase
        return op;
    endfunction

    function automatic imm_fmt_t imm_format(input opcode_t op);
        imm_fmt_t fmt;
        case (op)
            OPCODE_OP_IMM, OPCODE_LOAD, OPCODE_JALR, OPCODE_SYSTEM: fmt = IMM_I;
            OPCODE_STORE:                                           fmt = IMM_S;
            OPCODE_BRANCH:                                          fmt = IMM_B;
            OPCODE_LUI, OPCODE_AUIPC:                               fmt = IMM_U;
            OPCODE_JAL:                                             fmt = IMM_J;
            default:                                                fmt = IMM_R;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/stage_instruction_decode_immediate_generator.sv
// Combinational immediate extraction: picks the format from the opcode and
// sign-extends the reassembled immediate to XLEN.
module immediate_generator
    import stage_instruction_decode_pkg::*;
#(
    parameter int XLEN = ARCH_XLEN,
    parameter int ILEN = ARCH_ILEN
) (
    input  logic [ILEN-1:0] instr_bits,
    output logic [XLEN-1:0] imm
);

    always_comb begin
        imm = '0;
        case (imm_format(extract_opcode(instr_bits)))
            IMM_I: imm = XLEN'($signed(instr_bits[31:20]));
            IMM_S: imm = XLEN'($signed({instr_bits[31:25], instr_bits[11:7]}));
            IMM_B: imm = XLEN'($signed({instr_bits[31], instr_bits[7], instr_bits[30:25],
                                        instr_bits[11:8], 1'b0}));
            IMM_U: imm = XLEN'($signed({instr_bits[31:12], 12'b0}));
            IMM_J: imm = XLEN'($signed({instr_bits[31], instr_bits[19:12], instr_bits[20],
                                        instr_bits[30:21], 1'b0}));
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/stage_instruction_decode.sv
// Instruction decode stage: drives register-file addresses, waits out the read
// latency, then presents decoded fields under the enable/is_complete handshake.
module stage_instruction_decode
    import stage_instruction_decode_pkg::*;
#(
    parameter int XLEN             = ARCH_XLEN,
    parameter int ILEN             = ARCH_ILEN,
    parameter int REG_READ_LATENCY = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [ILEN-1:0]      instr_bits,
    input  logic [XLEN-1:0]      pc,
    input  logic [XLEN-1:0]      rf_rs1_data,
    input  logic [XLEN-1:0]      rf_rs2_data,
    output logic [REG_IDX_W-1:0] rf_rs1_addr,
    output logic [REG_IDX_W-1:0] rf_rs2_addr,
    output logic                 is_complete,
    output logic                 is_halted,
    output opcode_t              opcode,
    output logic [4:0]           rd,
    output logic [2:0]           funct3,
    output logic [6:0]           funct7,
    output logic [XLEN-1:0]      imm,
    output logic [XLEN-1:0]      rs1_value,
    output logic [XLEN-1:0]      rs2_value,
    output logic [XLEN-1:0]      pc_out
);

    localparam int CNT_W = (REG_READ_LATENCY < 1) ? 1 : $clog2(REG_READ_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(REG_READ_LATENCY);

    typedef struct packed {
        opcode_t         opcode;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] rs1_value;
        logic [XLEN-1:0] rs2_value;
        logic [XLEN-1:0] pc;
    } decode_t;

    logic [CNT_W-1:0] remaining_cycles;
    logic             read_complete;
    logic             next_halted;
    logic [XLEN-1:0]  live_imm;
    decode_t          live;
    decode_t          saved;
    decode_t          shown;

    assign rf_rs1_addr = instr_bits[19:15];
    assign rf_rs2_addr = instr_bits[24:20];

    immediate_generator #(
        .XLEN (XLEN),
        .ILEN (ILEN)
    ) u_immediate_generator (
        .instr_bits (instr_bits),
        .imm        (live_imm)
    );

    // x0 always reads as zero, whatever the register file returns.
    always_comb begin
        live           = '0;
        live.opcode    = extract_opcode(instr_bits);
        live.rd        = instr_bits[11:7];
        live.funct3    = instr_bits[14:12];
        live.funct7    = instr_bits[31:25];
        live.imm       = live_imm;
        live.rs1_value = (rf_rs1_addr == '0) ? '0 : rf_rs1_data;
        live.rs2_value = (rf_rs2_addr == '0) ? '0 : rf_rs2_data;
        live.pc        = pc;
    end

    assign read_complete = (remaining_cycles == '0);
    assign next_halted   = is_halted | (enable & read_complete & (live.opcode == OPCODE_UNKNOWN));
    assign is_complete   = enable & read_complete & ~is_halted & ~next_halted;
    assign shown         = (enable & ~is_halted) ? live : saved;

    assign opcode    = shown.opcode;
    assign rd        = shown.rd;
    assign funct3    = shown.funct3;
    assign funct7    = shown.funct7;
    assign imm       = shown.imm;
    assign rs1_value = shown.rs1_value;
    assign rs2_value = shown.rs2_value;
    assign pc_out    = shown.pc;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            remaining_cycles <= CNT_LOAD;
        end else if (!enable) begin
            remaining_cycles <= CNT_LOAD;
        end else if (remaining_cycles != '0) begin
            remaining_cycles <= remaining_cycles - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            is_halted <= 1'b0;
        end else begin
            is_halted <= next_halted;
        end
    end

    // The saved set is what the stage shows whenever it is idle or halted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            saved <= '0;
        end else if (is_complete) begin
            saved <= live;
        end
    end

endmodule

// File: tb/tb_stage_instruction_decode.sv
// Scoreboard bench for the decode stage: two instances (latency 1 and 2),
// stimulus pushes expected decodes, per-instance monitors pop and compare.
module tb_stage_instruction_decode;
    import stage_instruction_decode_pkg::*;

    typedef struct {
        string       name;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic [31:0] rs1_value;
        logic [31:0] rs2_value;
        logic [31:0] pc;
        int          start;
        int          latency;
    } expect_t;

    expect_t q1[$];
    expect_t q2[$];
    expect_t none;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic        clock;
    logic        reset;
    logic        en1, en2;
    logic [31:0] instr_bits, pc, rf_rs1_data, rf_rs2_data;

    logic [4:0]  rs1_addr1, rs2_addr1, rs1_addr2, rs2_addr2;
    logic        done1, done2, halted1, halted2;
    opcode_t     op1, op2;
    logic [4:0]  rd1, rd2;
    logic [2:0]  f3_1, f3_2;
    logic [6:0]  f7_1, f7_2;
    logic [31:0] imm1, imm2, rs1v1, rs1v2, rs2v1, rs2v2, pco1, pco2;
    bit          prev1, prev2;

    stage_instruction_decode #(.REG_READ_LATENCY(1)) dut1 (
        .clock(clock), .reset(reset), .enable(en1), .instr_bits(instr_bits), .pc(pc),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .rf_rs1_addr(rs1_addr1), .rf_rs2_addr(rs2_addr1),
        .is_complete(done1), .is_halted(halted1), .opcode(op1), .rd(rd1),
        .funct3(f3_1), .funct7(f7_1), .imm(imm1), .rs1_value(rs1v1), .rs2_value(rs2v1),
        .pc_out(pco1)
    );

    stage_instruction_decode #(.REG_READ_LATENCY(2)) dut2 (
        .clock(clock), .reset(reset), .enable(en2), .instr_bits(instr_bits), .pc(pc),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .rf_rs1_addr(rs1_addr2), .rf_rs2_addr(rs2_addr2),
        .is_complete(done2), .is_halted(halted2), .opcode(op2), .rd(rd2),
        .funct3(f3_2), .funct7(f7_2), .imm(imm2), .rs1_value(rs1v2), .rs2_value(rs2v2),
        .pc_out(pco2)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    function automatic expect_t mk(input string name, input logic [6:0] opc, input logic [4:0] rdv,
                                   input logic [2:0] f3, input logic [6:0] f7,
                                   input logic [31:0] immv, input logic [31:0] r1,
                                   input logic [31:0] r2, input logic [31:0] pcv, input int lat);
        expect_t e;
        e.name = name; e.opcode = opc; e.rd = rdv; e.funct3 = f3; e.funct7 = f7;
        e.imm = immv; e.rs1_value = r1; e.rs2_value = r2; e.pc = pcv;
        e.start = 0; e.latency = lat;
        return e;
    endfunction

    task automatic compare_decode(input expect_t e, input logic [6:0] opc, input logic [4:0] rdv,
                                  input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [31:0] immv, input logic [31:0] r1,
                                  input logic [31:0] r2, input logic [31:0] pcv);
        check_output({e.name, ".latency"}, 32'(cyc - e.start), 32'(e.latency));
        check_output({e.name, ".opcode"}, 32'(opc), 32'(e.opcode));
        check_output({e.name, ".rd"}, 32'(rdv), 32'(e.rd));
        check_output({e.name, ".funct3"}, 32'(f3), 32'(e.funct3));
        check_output({e.name, ".funct7"}, 32'(f7), 32'(e.funct7));
        check_output({e.name, ".imm"}, immv, e.imm);
        check_output({e.name, ".rs1_value"}, r1, e.rs1_value);
        check_output({e.name, ".rs2_value"}, r2, e.rs2_value);
        check_output({e.name, ".pc_out"}, pcv, e.pc);
    endtask

    // Monitors: each rising is_complete must match the oldest pending decode.
    initial forever begin
        @(negedge clock);
        if (done1 && !prev1) begin
            if (q1.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL dut1.unexpected_complete: got is_complete=1, expected 0");
            end else begin
                compare_decode(q1.pop_front(), op1, rd1, f3_1, f7_1, imm1, rs1v1, rs2v1, pco1);
            end
        end
        prev1 = done1;
    end

    initial forever begin
        @(negedge clock);
        if (done2 && !prev2) begin
            if (q2.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL dut2.unexpected_complete: got is_complete=1, expected 0");
            end else begin
                compare_decode(q2.pop_front(), op2, rd2, f3_2, f7_2, imm2, rs1v2, rs2v2, pco2);
            end
        end
        prev2 = done2;
    end

    task automatic apply_stimulus(input int sel, input logic [31:0] instr, input logic [31:0] pcv,
                                  input logic [31:0] d1, input logic [31:0] d2,
                                  input bit push, input expect_t e);
        expect_t x;
        x = e;
        instr_bits  = instr;
        pc          = pcv;
        rf_rs1_data = d1;
        rf_rs2_data = d2;
        x.start     = cyc;
        if (sel == 1) begin
            if (push) q1.push_back(x);
            en1 = 1'b1;
        end else begin
            if (push) q2.push_back(x);
            en2 = 1'b1;
        end
    endtask

    task automatic wait_complete(input int sel, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if ((sel == 1) ? done1 : done2) begin
                seen = 1'b1;
                break;
            end
        end
        check_output({name, ".completed"}, 32'(seen), 32'd1);
    endtask

    task automatic release_enable();
        @(posedge clock); #1;
        en1 = 1'b0;
        en2 = 1'b0;
        @(posedge clock); #1;
    endtask

    initial begin
        reset = 1'b0; en1 = 1'b0; en2 = 1'b0;
        instr_bits = '0; pc = '0; rf_rs1_data = '0; rf_rs2_data = '0;
        #2;
        check_output("reset.done1", 32'(done1), 32'd0);
        check_output("reset.halted1", 32'(halted1), 32'd0);
        check_output("reset.opcode1", 32'(op1), 32'd0);
        check_output("reset.imm2", imm2, 32'd0);
        check_output("reset.pc_out2", pco2, 32'd0);
        check_output("reset.halted2", 32'(halted2), 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;

        // Latency-1 decodes
        apply_stimulus(1, 32'hFFB10093, 32'h100, 32'h10, 32'h55, 1'b1,
                       mk("addi", 7'h13, 5'd1, 3'd0, 7'h7F, 32'hFFFFFFFB, 32'h10, 32'h55, 32'h100, 1));
        @(negedge clock);
        check_output("addi.rf_rs1_addr", 32'(rs1_addr1), 32'd2);
        check_output("addi.rf_rs2_addr", 32'(rs2_addr1), 32'd27);
        check_output("addi.cycle0_done", 32'(done1), 32'd0);
        wait_complete(1, "addi");
        release_enable();
        apply_stimulus(1, 32'h123452B7, 32'h104, 32'h11111111, 32'h22222222, 1'b1,
                       mk("lui", 7'h37, 5'd5, 3'd5, 7'h09, 32'h12345000, 32'h11111111, 32'h22222222, 32'h104, 1));
        wait_complete(1, "lui");
        release_enable();

        // Latency-2 decodes
        apply_stimulus(2, 32'hFE000EE3, 32'h200, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1,
                       mk("beq", 7'h63, 5'h1D, 3'd0, 7'h7F, 32'hFFFFFFFC, 32'h0, 32'h0, 32'h200, 2));
        wait_complete(2, "beq");
        release_enable();
        apply_stimulus(2, 32'h008000EF, 32'h204, 32'h33333333, 32'h44444444, 1'b1,
                       mk("jal", 7'h6F, 5'd1, 3'd0, 7'h00, 32'h8, 32'h0, 32'h44444444, 32'h204, 2));
        wait_complete(2, "jal");
        release_enable();
        apply_stimulus(2, 32'h0021A623, 32'h208, 32'h1000, 32'hCAFE, 1'b1,
                       mk("sw", 7'h23, 5'd12, 3'd2, 7'h00, 32'hC, 32'h1000, 32'hCAFE, 32'h208, 2));
        @(negedge clock);
        check_output("sw.rf_rs1_addr", 32'(rs1_addr2), 32'd3);
        check_output("sw.rf_rs2_addr", 32'(rs2_addr2), 32'd2);
        wait_complete(2, "sw");
        release_enable();

        // Enable dropped mid-read: outputs fall back to the saved SW decode
        apply_stimulus(2, 32'hFFB10093, 32'h20C, 32'h10, 32'h55, 1'b0, none);
        @(posedge clock); #1;
        en2 = 1'b0;
        @(negedge clock);
        check_output("drop.done", 32'(done2), 32'd0);
        check_output("drop.opcode", 32'(op2), 32'h23);
        check_output("drop.imm", imm2, 32'hC);
        check_output("drop.pc_out", pco2, 32'h208);
        check_output("drop.rs1_value", rs1v2, 32'h1000);
        @(posedge clock); #1;
        apply_stimulus(2, 32'hFFB10093, 32'h20C, 32'h10, 32'h55, 1'b1,
                       mk("addi_retry", 7'h13, 5'd1, 3'd0, 7'h7F, 32'hFFFFFFFB, 32'h10, 32'h55, 32'h20C, 2));
        wait_complete(2, "addi_retry");
        release_enable();

        // Illegal opcode halts the stage for good
        apply_stimulus(2, 32'h00000000, 32'h300, 32'h0, 32'h0, 1'b0, none);
        repeat (3) @(negedge clock);
        check_output("illegal.halted_at_read", 32'(halted2), 32'd0);
        @(negedge clock);
        check_output("illegal.halted_after", 32'(halted2), 32'd1);
        check_output("illegal.opcode_saved", 32'(op2), 32'h13);
        check_output("illegal.pc_saved", pco2, 32'h20C);
        repeat (3) @(negedge clock);
        release_enable();
        apply_stimulus(2, 32'h123452B7, 32'h304, 32'h1, 32'h2, 1'b0, none);
        repeat (5) @(negedge clock);
        check_output("halted.sticky", 32'(halted2), 32'd1);
        check_output("halted.opcode", 32'(op2), 32'h13);
        check_output("halted.imm", imm2, 32'hFFFFFFFB);
        @(posedge clock); #1;
        en2 = 1'b0;

        // Reset clears halt and saved set, including mid-read
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        check_output("rst.halted", 32'(halted2), 32'd0);
        check_output("rst.opcode", 32'(op2), 32'd0);
        check_output("rst.imm", imm2, 32'd0);
        check_output("rst.pc_out", pco2, 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        apply_stimulus(2, 32'hFFB10093, 32'h400, 32'h10, 32'h55, 1'b0, none);
        @(posedge clock); #1;
        reset = 1'b0;
        en2 = 1'b0;
        #1;
        check_output("midrst.done", 32'(done2), 32'd0);
        check_output("midrst.opcode", 32'(op2), 32'd0);
        check_output("midrst.rs1_value", rs1v2, 32'd0);
        check_output("midrst.halted", 32'(halted2), 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        apply_stimulus(2, 32'hFFB10093, 32'h400, 32'h10, 32'h55, 1'b1,
                       mk("addi_after_reset", 7'h13, 5'd1, 3'd0, 7'h7F, 32'hFFFFFFFB, 32'h10, 32'h55, 32'h400, 2));
        wait_complete(2, "addi_after_reset");
        release_enable();

        repeat (2) @(negedge clock);
        check_output("queue1.drained", 32'(q1.size()), 32'd0);
        check_output("queue2.drained", 32'(q2.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
